mode_sequencer: RTL

- Parametrised successor to the display-mode FSM.
- Selects which pattern engine drives the output: mode 0 is the idle/grid display, modes 1..NUM_MODES-1 are engines such as evolved grid and LFSR.
- Adds request debouncing, a stop handshake with the running engine, and a one-cycle switch strobe.
- Sits between the board mode switches and the pattern engines/output mux.

---
 rtl/mode_sequencer_if.sv | 33 +++
 rtl/mode_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mode_sequencer_if.sv
// Handshake bundle between the board mode switches, the mode sequencer and
// the pattern engines. The sequencer uses the slave view.
interface mode_sequencer_if #(
    parameter int MODE_W = 2
);
    logic [MODE_W-1:0] req;
    logic              stop_ack;
    logic [MODE_W-1:0] active;
    logic              active_valid;
    logic              stop_req;
    logic              switch_pulse;
    logic              timeout_err;

    modport master (
        output req,
        output stop_ack,
        input  active,
        input  active_valid,
        input  stop_req,
        input  switch_pulse,
        input  timeout_err
    );

    modport slave (
        input  req,
        input  stop_ack,
        output active,
        output active_valid,
        output stop_req,
        output switch_pulse,
        output timeout_err
    );
endinterface

// File: rtl/mode_sequencer.sv
// Display-mode sequencer: debounces mode requests, stops the running engine
// by handshake and strobes every change of the granted mode.
// Optional stop timeout enabled by defining MODE_SEQ_TIMEOUT_EN.
module mode_sequencer #(
    parameter int MODE_W         = 2,
    parameter int NUM_MODES      = 4,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    mode_sequencer_if.slave  bus
);

    localparam int HC_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [MODE_W:0] LP_NUM_MODES = (MODE_W + 1)'(NUM_MODES);
    localparam logic [HC_W-1:0] LP_HOLD      = HC_W'(HOLD_CYCLES);
    localparam logic [HC_W-1:0] LP_HOLD_ONE  = HC_W'(1);

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_QUAL = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_STOP = 3'd4;

    logic [2:0]        r_state;
    logic [MODE_W-1:0] r_active;
    logic [MODE_W-1:0] r_cand;
    logic [HC_W-1:0]   r_hold_cnt;
    logic              r_active_valid;
    logic              r_stop_req;
    logic              r_switch_pulse;

    logic [MODE_W-1:0] w_req_eff;
    logic [HC_W-1:0]   w_hold_inc;
    logic              w_timeout;

    // Out-of-range codes are folded onto the idle mode.
    assign w_req_eff  = ({1'b0, bus.req} < LP_NUM_MODES) ? bus.req : '0;
    assign w_hold_inc = (r_hold_cnt == LP_HOLD) ? r_hold_cnt : r_hold_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_INIT;
            r_active       <= '0;
            r_cand         <= '0;
            r_hold_cnt     <= '0;
            r_active_valid <= 1'b0;
            r_stop_req     <= 1'b0;
            r_switch_pulse <= 1'b0;
        end else begin
            r_switch_pulse <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_state        <= S_IDLE;
                    r_active_valid <= 1'b1;
                end
                S_IDLE: begin
                    if (w_req_eff != '0) begin
                        r_cand     <= w_req_eff;
                        r_hold_cnt <= LP_HOLD_ONE;
                        if (HOLD_CYCLES == 1) begin
                            r_state        <= S_RUN;
                            r_active       <= w_req_eff;
                            r_switch_pulse <= 1'b1;
                        end else begin
                            r_state <= S_QUAL;
                        end
                    end
                end
                S_QUAL: begin
                    if (w_req_eff == r_cand) begin
                        r_hold_cnt <= w_hold_inc;
                        if (w_hold_inc == LP_HOLD) begin
                            r_state        <= S_RUN;
                            r_active       <= r_cand;
                            r_switch_pulse <= 1'b1;
                        end
                    end else if (w_req_eff == '0) begin
                        r_state    <= S_IDLE;
                        r_hold_cnt <= '0;
                    end else begin
                        r_cand     <= w_req_eff;
                        r_hold_cnt <= LP_HOLD_ONE;
                    end
                end
                S_RUN: begin
                    if (w_req_eff != r_active) begin
                        r_state        <= S_STOP;
                        r_stop_req     <= 1'b1;
                        r_active_valid <= 1'b0;
                    end
                end
                S_STOP: begin
                    // req is ignored here: the stop always completes and the
                    // next mode is requalified from IDLE.
                    if (bus.stop_ack || w_timeout) begin
                        r_state        <= S_IDLE;
                        r_stop_req     <= 1'b0;
                        r_active       <= '0;
                        r_active_valid <= 1'b1;
                        r_switch_pulse <= 1'b1;
                        r_hold_cnt     <= '0;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

`ifdef MODE_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] LP_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;

    // An ack on the same edge as the expiry wins, so no error is flagged.
    assign w_timeout = (r_state == S_STOP) && !bus.stop_ack && (r_to_cnt == LP_TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != S_STOP) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_timeout        = 1'b0;
    assign bus.timeout_err  = 1'b0;
`endif

    assign bus.active       = r_active;
    assign bus.active_valid = r_active_valid;
    assign bus.stop_req     = r_stop_req;
    assign bus.switch_pulse = r_switch_pulse;

endmodule
